sevenseg_scan_ctrl: RTL

Time-multiplexed scan controller for an NDIGITS common-anode seven-segment display. It shares one internal sevenseg_hex decoder across all digits by cycling the digit select. It also sequences anode enables with anti-ghosting blank time, double-buffers the displayed value so frames never tear, and applies per-digit enable and leading-zero suppression. It sits between board-level user logic and the display pins.

---
 rtl/sevenseg_scan_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// One shared hex decoder, blanked slot starts, frame-synchronous double buffering.
module sevenseg_scan_ctrl #(
  parameter int unsigned NDIGITS      = 8,
  parameter int unsigned SLOT_CYCLES  = 1000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp,
  input  logic                   load,
  input  logic [NDIGITS-1:0]     digit_en,
  input  logic                   lz_en,
  output logic [6:0]             segs_l,
  output logic                   dp_l,
  output logic [NDIGITS-1:0]     an_l,
  output logic                   frame_start,
  output logic                   pending
);

  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned DIG_W = $clog2(NDIGITS);
  localparam int unsigned VAL_W = 4 * NDIGITS;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIG_W-1:0]     dig_q, dig_d;
  logic [VAL_W-1:0]     disp_q, pbuf_q;
  logic [NDIGITS-1:0]   ddp_q, pdp_q;
  logic                 pend_q;
  logic [6:0]           segs_q;
  logic                 dp_q;
  logic [NDIGITS-1:0]   an_q;
  logic                 frame_q;

  logic                 slot_end_c;
  logic                 boundary_c;
  logic [NDIGITS-1:0]   upper_zero_c;
  logic                 suppress_c;
  logic [3:0]           nib_c;

  function automatic logic [6:0] sevenseg_hex(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'b0000001;
      4'h1:    return 7'b1001111;
      4'h2:    return 7'b0010010;
      4'h3:    return 7'b0000110;
      4'h4:    return 7'b1001100;
      4'h5:    return 7'b0100100;
      4'h6:    return 7'b0100000;
      4'h7:    return 7'b0001111;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0001100;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b1100000;
      4'hC:    return 7'b1110010;
      4'hD:    return 7'b1000010;
      4'hE:    return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Slot counter and digit index advance; the wrap to digit 0 is the frame boundary.
  always_comb begin
    slot_end_c = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
    boundary_c = slot_end_c && (dig_q == DIG_W'(NDIGITS - 1));
    cnt_d      = slot_end_c ? '0 : cnt_q + CNT_W'(1);
    dig_d      = dig_q;
    if (slot_end_c) begin
      dig_d = (dig_q == DIG_W'(NDIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
    end
    state_d = ((BLANK_CYCLES != 0) && (cnt_d < CNT_W'(BLANK_CYCLES))) ? ST_BLANK : ST_DRIVE;
  end

  // upper_zero_c[i] is set when display nibbles i..NDIGITS-1 are all zero.
  always_comb begin
    upper_zero_c = '0;
    upper_zero_c[NDIGITS-1] = (disp_q[VAL_W-1 -: 4] == 4'h0);
    for (int i = int'(NDIGITS) - 2; i >= 0; i--) begin
      upper_zero_c[i] = upper_zero_c[i+1] && (disp_q[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    nib_c      = disp_q[{dig_q, 2'b00} +: 4];
    suppress_c = !digit_en[dig_q] ||
                 (lz_en && (dig_q != '0) && upper_zero_c[dig_q]);
  end

  // Scan state, buffers and registered pin drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      dig_q   <= '0;
      disp_q  <= '0;
      ddp_q   <= '0;
      pbuf_q  <= '0;
      pdp_q   <= '0;
      pend_q  <= 1'b0;
      segs_q  <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;

      if (boundary_c) begin
        if (load) begin
          disp_q <= value;
          ddp_q  <= dp;
          pend_q <= 1'b0;
        end else if (pend_q) begin
          disp_q <= pbuf_q;
          ddp_q  <= pdp_q;
          pend_q <= 1'b0;
        end
      end else if (load) begin
        pbuf_q <= value;
        pdp_q  <= dp;
        pend_q <= 1'b1;
      end

      frame_q <= (cnt_q == '0) && (dig_q == '0);

      if ((state_q == ST_BLANK) || suppress_c) begin
        an_q   <= '1;
        segs_q <= 7'h7F;
        dp_q   <= 1'b1;
      end else begin
        an_q   <= ~(NDIGITS'(1) << dig_q);
        segs_q <= sevenseg_hex(nib_c);
        dp_q   <= ~ddp_q[dig_q];
      end
    end
  end

  assign segs_l      = segs_q;
  assign dp_l        = dp_q;
  assign an_l        = an_q;
  assign frame_start = frame_q;
  assign pending     = pend_q;

endmodule
